// File: rtl/simon_input_checker.sv
// Simon player-input checker: turns debounced button levels into single accepted
// presses, compares them against the sequencer's expected colours, reports a verdict.
module simon_input_checker #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int TMR_W          = 26,
   parameter int IDX_W          = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       bp,
   input  logic             start,
   input  logic [IDX_W:0]   round_len,
   input  logic [1:0]       exp_color,
   output logic [IDX_W-1:0] exp_idx,
   output logic             busy,
   output logic             press_valid,
   output logic [1:0]       press_color,
   output logic             done,
   output logic             pass,
   output logic [1:0]       err,
   output logic [1:0]       state_dbg
);

   // Handshake: start is a one-cycle request, accepted only in IDLE (busy low);
   // done is a one-cycle pulse with pass/err valid and held until the next accepted start.
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      VERDICT      = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_COLOR = 2'b01;
   localparam logic [1:0] ERR_TIME  = 2'b10;
   localparam logic [1:0] ERR_MULTI = 2'b11;

   // Assert asynchronously, release on the second clock so the first state update is a full cycle.
   logic [1:0] rst_sync;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_int_n = rst_sync[1];

   state_t           state, state_nx;
   logic [3:0]       bp_q;
   logic [TMR_W-1:0] timer, timer_nx;
   logic [IDX_W:0]   len_q, len_nx;
   logic [IDX_W-1:0] idx_nx;
   logic             busy_nx, press_valid_nx, done_nx, pass_nx;
   logic [1:0]       press_color_nx, err_nx;

   logic             press_edge;
   logic [2:0]       bit_count;
   logic [1:0]       bp_color;
   logic             last_press;
   logic             timed_out;

   assign press_edge = (bp_q == 4'b0000) && (bp != 4'b0000);
   assign bit_count  = {2'b00, bp[0]} + {2'b00, bp[1]} + {2'b00, bp[2]} + {2'b00, bp[3]};
   assign bp_color   = bp[3] ? 2'd0 : (bp[2] ? 2'd1 : (bp[1] ? 2'd2 : 2'd3));
   assign last_press = ({1'b0, exp_idx} == (len_q - (IDX_W+1)'(1)));
   assign timed_out  = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
   assign state_dbg  = state;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state       <= IDLE;
         bp_q        <= 4'b0000;
         timer       <= '0;
         len_q       <= '0;
         exp_idx     <= '0;
         busy        <= 1'b0;
         press_valid <= 1'b0;
         press_color <= 2'd0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err         <= ERR_NONE;
      end else begin
         state       <= state_nx;
         bp_q        <= bp;
         timer       <= timer_nx;
         len_q       <= len_nx;
         exp_idx     <= idx_nx;
         busy        <= busy_nx;
         press_valid <= press_valid_nx;
         press_color <= press_color_nx;
         done        <= done_nx;
         pass        <= pass_nx;
         err         <= err_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      timer_nx       = timer;
      len_nx         = len_q;
      idx_nx         = exp_idx;
      busy_nx        = busy;
      press_valid_nx = 1'b0;
      press_color_nx = press_color;
      done_nx        = 1'b0;
      pass_nx        = pass;
      err_nx         = err;

      unique case (state)
         IDLE: begin
            if (start) begin
               len_nx   = round_len;
               idx_nx   = '0;
               timer_nx = '0;
               pass_nx  = 1'b0;
               err_nx   = ERR_NONE;
               busy_nx  = 1'b1;
               if (round_len == '0) begin
                  pass_nx  = 1'b1;
                  state_nx = VERDICT;
               end else begin
                  state_nx = WAIT_PRESS;
               end
            end
         end
         // A press edge wins over a timeout landing on the same cycle.
         WAIT_PRESS: begin
            if (press_edge) begin
               if (bit_count == 3'd1) begin
                  press_color_nx = bp_color;
                  press_valid_nx = 1'b1;
                  timer_nx       = '0;
                  state_nx       = WAIT_RELEASE;
               end else begin
                  err_nx   = ERR_MULTI;
                  state_nx = VERDICT;
               end
            end else if (timed_out) begin
               err_nx   = ERR_TIME;
               state_nx = VERDICT;
            end else begin
               timer_nx = timer + TMR_W'(1);
            end
         end
         WAIT_RELEASE: begin
            if (bp == 4'b0000) begin
               if (press_color != exp_color) begin
                  err_nx   = ERR_COLOR;
                  state_nx = VERDICT;
               end else if (last_press) begin
                  pass_nx  = 1'b1;
                  state_nx = VERDICT;
               end else begin
                  idx_nx   = exp_idx + IDX_W'(1);
                  timer_nx = '0;
                  state_nx = WAIT_PRESS;
               end
            end
         end
         VERDICT: begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_simon_input_checker.sv
// Directed bench for simon_input_checker with a short timeout; the sequencer is a
// bench-side colour table indexed by exp_idx.
module tb_simon_input_checker;

   localparam int T     = 20;
   localparam int TMR_W = 5;
   localparam int IDX_W = 4;

   logic             clk;
   logic             rst_n;
   logic [3:0]       bp;
   logic             start;
   logic [IDX_W:0]   round_len;
   logic [1:0]       exp_color;
   logic [IDX_W-1:0] exp_idx;
   logic             busy, press_valid, done, pass;
   logic [1:0]       press_color, err, state_dbg;

   logic [1:0] exp_seq [16];
   int total = 0;
   int bad   = 0;

   simon_input_checker #(
      .TIMEOUT_CYCLES(T),
      .TMR_W(TMR_W),
      .IDX_W(IDX_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bp(bp),
      .start(start),
      .round_len(round_len),
      .exp_color(exp_color),
      .exp_idx(exp_idx),
      .busy(busy),
      .press_valid(press_valid),
      .press_color(press_color),
      .done(done),
      .pass(pass),
      .err(err),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb exp_color = exp_seq[exp_idx];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, want);
      end
   endtask

   task automatic begin_round(input logic [IDX_W:0] len);
      start     = 1'b1;
      round_len = len;
      tick();
      start = 1'b0;
      chk("busy_on_start", {31'd0, busy}, 1);
   endtask

   task automatic do_press(input logic [1:0] col);
      bp = 4'b1000 >> col;
      tick();
      chk("press_valid", {31'd0, press_valid}, 1);
      chk("press_color", {30'd0, press_color}, {30'd0, col});
      bp = 4'b0000;
      tick();
      chk("press_valid_pulse", {31'd0, press_valid}, 0);
   endtask

   task automatic chk_verdict(input string tag, input logic p, input logic [1:0] e);
      chk({tag, "_done_pre"}, {31'd0, done}, 0);
      tick();
      chk({tag, "_done"}, {31'd0, done}, 1);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
      chk({tag, "_err"},  {30'd0, err},  {30'd0, e});
      tick();
      chk({tag, "_done_pulse"}, {31'd0, done}, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) exp_seq[i] = 2'd0;
      rst_n = 1'b0; bp = 4'b0000; start = 1'b0; round_len = '0;
      tick(); tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_pass", {31'd0, pass}, 0);
      chk("rst_err", {30'd0, err}, 0);
      chk("rst_idx", {28'd0, exp_idx}, 0);
      chk("rst_state", {30'd0, state_dbg}, 0);
      rst_n = 1'b1;
      tick(); tick(); tick();

      // round_len 0: immediate pass
      begin_round(5'd0);
      chk("len0_done_pre", {31'd0, done}, 0);
      tick();
      chk("len0_done", {31'd0, done}, 1);
      chk("len0_pass", {31'd0, pass}, 1);
      chk("len0_busy", {31'd0, busy}, 0);
      tick();
      chk("len0_pass_held", {31'd0, pass}, 1);

      // three-press pass, with an ignored start while busy
      exp_seq[0] = 2'd0; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1;
      begin_round(5'd3);
      chk("b_pass_cleared", {31'd0, pass}, 0);
      chk("b_idx0", {28'd0, exp_idx}, 0);
      do_press(2'd0);
      chk("b_idx1", {28'd0, exp_idx}, 1);
      start = 1'b1; round_len = 5'd3;
      tick();
      start = 1'b0;
      chk("b_busy_start_idx", {28'd0, exp_idx}, 1);
      chk("b_busy_start_state", {30'd0, state_dbg}, 1);
      do_press(2'd2);
      chk("b_idx2", {28'd0, exp_idx}, 2);
      do_press(2'd1);
      chk("b_busy_in_verdict", {31'd0, busy}, 1);
      chk_verdict("b", 1'b1, 2'b00);
      chk("b_pass_held", {31'd0, pass}, 1);

      // wrong colour on second press
      exp_seq[0] = 2'd3; exp_seq[1] = 2'd3;
      begin_round(5'd2);
      do_press(2'd3);
      chk("c_idx1", {28'd0, exp_idx}, 1);
      do_press(2'd1);
      chk_verdict("c", 1'b0, 2'b01);

      // timeout: verdict entered exactly T edges after start
      exp_seq[0] = 2'd2;
      begin_round(5'd1);
      repeat (T - 1) tick();
      chk("d_state_wait", {30'd0, state_dbg}, 1);
      tick();
      chk("d_state_verdict", {30'd0, state_dbg}, 3);
      chk_verdict("d", 1'b0, 2'b10);

      // press edge on the timeout cycle wins
      begin_round(5'd1);
      repeat (T - 1) tick();
      bp = 4'b0010;
      tick();
      chk("d2_press_valid", {31'd0, press_valid}, 1);
      chk("d2_state", {30'd0, state_dbg}, 2);
      chk("d2_err", {30'd0, err}, 0);
      bp = 4'b0000;
      tick();
      chk_verdict("d2", 1'b1, 2'b00);

      // two buttons on one edge
      begin_round(5'd1);
      bp = 4'b0110;
      tick();
      chk("e_no_press", {31'd0, press_valid}, 0);
      chk("e_state", {30'd0, state_dbg}, 3);
      bp = 4'b0000;
      chk_verdict("e", 1'b0, 2'b11);

      // extra button while first is held is ignored
      exp_seq[0] = 2'd0;
      begin_round(5'd1);
      bp = 4'b1000;
      tick();
      chk("e2_press_valid", {31'd0, press_valid}, 1);
      chk("e2_color", {30'd0, press_color}, 0);
      bp = 4'b1100;
      tick();
      chk("e2_no_second", {31'd0, press_valid}, 0);
      chk("e2_state", {30'd0, state_dbg}, 2);
      bp = 4'b0000;
      tick();
      chk_verdict("e2", 1'b1, 2'b00);

      // button held across start must be released first
      exp_seq[0] = 2'd3;
      bp = 4'b0001;
      tick();
      begin_round(5'd1);
      tick(); tick(); tick();
      chk("f_held_no_press", {31'd0, press_valid}, 0);
      chk("f_held_state", {30'd0, state_dbg}, 1);
      bp = 4'b0000;
      tick();
      do_press(2'd3);
      chk_verdict("f", 1'b1, 2'b00);

      // reset mid-WAIT_RELEASE with a button held
      exp_seq[0] = 2'd0;
      begin_round(5'd1);
      bp = 4'b1000;
      tick();
      chk("g_state_release", {30'd0, state_dbg}, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("g_rst_busy", {31'd0, busy}, 0);
      chk("g_rst_color", {30'd0, press_color}, 0);
      chk("g_rst_pv", {31'd0, press_valid}, 0);
      chk("g_rst_state", {30'd0, state_dbg}, 0);
      tick(); tick();
      bp = 4'b0000;
      rst_n = 1'b1;
      tick(); tick(); tick();
      begin_round(5'd1);
      do_press(2'd0);
      chk_verdict("g", 1'b1, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/simon_input_checker.md
# simon_input_checker

Player-input controller for the Simon game. Consumes the four debounced button levels from the button debouncing stage, arbitrates them into single accepted presses, and checks each press against the expected colour sequence held by the game sequencer. Sits between the debounced button vector and the top-level game FSM, which starts a round and reads back a pass/fail verdict.

## Interface
- `TIMEOUT_CYCLES`, 50_000_000: maximum idle cycles allowed between presses (1 s at 50 MHz).
- `TMR_W`, 26: timer width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.
- `IDX_W`, 4: sequence index width (maximum round length 2^IDX_W = 16).

- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bp` in 4: debounced button levels, `{b0,b1,b2,b3}`; colour k is `bp[3-k]`.
- `start` in 1: one-cycle request to begin checking a round; ignored while `busy`.
- `round_len` in IDX_W+1: number of presses expected, sampled on accepted `start`; legal range 0..16.
- `exp_color` in 2: expected colour at `exp_idx`, supplied combinationally by the sequencer.
- `exp_idx` out IDX_W: index of the press currently expected.
- `busy` out 1: high from accepted `start` until verdict.
- `press_valid` out 1: one-cycle pulse per accepted press.
- `press_color` out 2: colour of the last accepted press; held until the next one.
- `done` out 1: one-cycle verdict pulse.
- `pass` out 1: verdict, held from `done` until the next accepted `start`.
- `err` out 2: failure cause, held like `pass`: 00 none, 01 wrong colour, 10 timeout, 11 multi-press.

## Operation
- `bp_q`: registered copy of `bp`, reset 0. Press edge = `bp_q == 0` and `bp != 0`.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, VERDICT.
- IDLE: `start` -> latch `round_len`, clear `exp_idx`, timer, `pass`, `err`; `busy`=1. If `round_len == 0` go to VERDICT with pass; otherwise go to WAIT_PRESS.
- WAIT_PRESS: timer increments each cycle.
  - Press edge with exactly one bit set: `press_color` is that colour, `press_valid` pulses, timer clears, go to WAIT_RELEASE.
  - Press edge with two or more bits set: `err`=11, go to VERDICT.
  - Timer reaches TIMEOUT_CYCLES-1 with no press edge: `err`=10, go to VERDICT.
  - Buttons already held on entry do not count; they must be released first (the edge rule enforces this).
  - On the same cycle, press edge takes priority over timeout.
- WAIT_RELEASE: timer is frozen. Extra buttons pressed while the first is held are ignored.
  - When `bp == 0`: compare `press_color` with `exp_color`.
  - Mismatch: `err`=01, go to VERDICT.
  - Match and `exp_idx == round_len-1`: `pass`=1, go to VERDICT.
  - Match otherwise: `exp_idx`++, timer clears, go to WAIT_PRESS.
- VERDICT: `done`=1 and `busy`=0 for one cycle, then go to IDLE. `pass` and `err` stay valid until the next `start`.
- `start` outside IDLE has no effect.

## Timing
- Reset (async, any state): state IDLE. `busy`, `press_valid`, `press_color`, `done`, `pass`, `err`, `exp_idx`, `bp_q` and timer all 0.
- Deassertion of `rst_n` must be synchronised internally, so that the first state update occurs on a full clock.
- `start` sampled at edge N: `busy`=1 after N. If `round_len` = 0: `done`=1, `pass`=1 after N+1.
- Press edge sampled at edge M: `press_valid`/`press_color` valid after M, for one cycle.
- Release sampled at edge R: `exp_idx` advances after R, or VERDICT is entered after R. `done` is high during cycle R+1, and `busy` drops in the same cycle.
- Timeout: the verdict is entered exactly TIMEOUT_CYCLES edges after entry to WAIT_PRESS.
- `exp_color` must be stable within one cycle of an `exp_idx` change.
- Minimum press-to-press spacing is 3 cycles (press, release, re-press edge).

## Test plan
- Reset mid-WAIT_RELEASE with `bp`=1000 held -> all outputs 0 immediately. After release, `start` with `round_len`=1 is accepted normally.
- `round_len`=3, expected 0,2,1; press/release colours 0,2,1 -> three `press_valid` pulses with colours 0,2,1; `done`=1, `pass`=1, `err`=00; `exp_idx` steps 0->1->2.
- `round_len`=2, expected 3,3; press colours 3,1 -> `done` one cycle after the second release, `pass`=0, `err`=01.
- `TIMEOUT_CYCLES`=20, `round_len`=1, no press -> `done` 21 cycles after `start`, `err`=10; a press edge on cycle 19 -> no timeout.
- `bp` going 0000->0110 in WAIT_PRESS -> `err`=11, no `press_valid`. A second case, `bp` 0000->1000->1100->0000 with expected colour 0 -> single accepted press, pass.
- `start` while `bp`=0001 held, `round_len`=1 -> no press accepted until a release and re-press. `start` pulsed while `busy` -> ignored, `exp_idx` unchanged. `round_len`=0 -> immediate pass.
